// File: rtl/master_rx_engine_pkg.sv
// rtl/master_rx_engine_pkg.sv - shared state encoding and command constants for the rx engine
package master_rx_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [1:0] INSTR_READ = 2'b11;

endpackage

// File: rtl/master_rx_engine_rx_fifo.sv
// rtl/master_rx_engine_rx_fifo.sv - registered word FIFO between the assembler and the output stream
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/master_rx_engine.sv
// rtl/master_rx_engine.sv - serial-lane burst receiver assembling words into an output FIFO
module master_rx_engine
  import master_rx_engine_pkg::*;
#(
  parameter int DATA_LEN   = 8,
  parameter int BURST_LEN  = 13,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           instruction,
  input  logic                 approval_grant,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic                 slave_valid,
  input  logic [LANES-1:0]     rx_data,
  output logic                 master_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_LEN-1:0]  out_data,
  output logic                 rx_done,
  output logic                 rx_abort,
  output logic                 busy
);

  localparam int BEATS   = DATA_LEN / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  state_t               state;
  logic [BURST_LEN-1:0] burst_lat;
  logic [BURST_LEN:0]   word_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [TMO_W-1:0]     idle_cnt;
  logic [DATA_LEN-1:0]  asm_reg;
  logic [DATA_LEN-1:0]  word_next;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FIFO_AW:0]     fifo_count;
  logic [DATA_LEN-1:0]  fifo_head;

  logic accept;
  logic last_beat;
  logic push;
  logic timed_out;

  assign master_ready = (state == ST_RECEIVE) && !fifo_full;
  assign accept       = slave_valid && master_ready;
  assign last_beat    = (beat_cnt == BEAT_W'(BEATS - 1));
  assign timed_out    = !accept && (idle_cnt == TMO_W'(TIMEOUT - 1));
  // A dropped grant wins over a beat arriving in the same cycle, so no partial word escapes.
  assign push         = accept && approval_grant && last_beat;
  assign busy         = (state != ST_IDLE);
  assign out_valid    = (fifo_count != '0);
  assign out_data     = fifo_empty ? '0 : fifo_head;

  // Merge the incoming beat so the final beat's bits land in the pushed word.
  always_comb begin
    word_next = asm_reg;
    word_next[beat_cnt*LANES +: LANES] = rx_data;
  end

  // Burst FSM: start on read grant, assemble beats, finish, or abort on grant loss/timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_lat <= '0;
      word_cnt  <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      asm_reg   <= '0;
      rx_done   <= 1'b0;
      rx_abort  <= 1'b0;
    end else begin
      rx_done  <= 1'b0;
      rx_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instruction == INSTR_READ && approval_grant) begin
            state     <= ST_RECEIVE;
            burst_lat <= burst_num;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            idle_cnt  <= '0;
            asm_reg   <= '0;
          end
        end
        ST_RECEIVE: begin
          if (!approval_grant || timed_out) begin
            state    <= ST_IDLE;
            rx_abort <= 1'b1;
            beat_cnt <= '0;
            idle_cnt <= '0;
            asm_reg  <= '0;
          end else if (accept) begin
            idle_cnt <= '0;
            if (last_beat) begin
              beat_cnt <= '0;
              asm_reg  <= '0;
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == {1'b0, burst_lat}) begin
                state   <= ST_DONE;
                rx_done <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              asm_reg  <= word_next;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  rx_fifo #(
    .WIDTH (DATA_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (word_next),
    .pop       (out_valid && out_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_master_rx_engine.sv
// tb/tb_master_rx_engine.sv - randomized self-checking bench for master_rx_engine
module tb_master_rx_engine;

  localparam int DATA_LEN   = 8;
  localparam int BURST_LEN  = 13;
  localparam int LANES      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 255;
  localparam int BEATS      = DATA_LEN / LANES;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           instruction;
  logic                 approval_grant;
  logic [BURST_LEN-1:0] burst_num;
  logic                 slave_valid;
  logic [LANES-1:0]     rx_data;
  logic                 master_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_LEN-1:0]  out_data;
  logic                 rx_done;
  logic                 rx_abort;
  logic                 busy;

  always #5 clk = ~clk;

  master_rx_engine #(
    .DATA_LEN   (DATA_LEN),
    .BURST_LEN  (BURST_LEN),
    .LANES      (LANES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .approval_grant (approval_grant),
    .burst_num      (burst_num),
    .slave_valid    (slave_valid),
    .rx_data        (rx_data),
    .master_ready   (master_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .rx_done        (rx_done),
    .rx_abort       (rx_abort),
    .busy           (busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a burst is a list of intended words; a word enters the
  // expected queue once all of its beats have been handed over.
  logic [DATA_LEN-1:0] exp_q[$];
  logic [DATA_LEN-1:0] words[16];
  bit m_recv, m_done_state, m_done_pulse, m_abort_pulse, start_req;
  int m_beat, m_word, m_idle, m_burst, beats_total;
  int sv_pct, or_pct, drop_at;
  int popped, model_aborts, seen_aborts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic choose_inputs();
    logic [DATA_LEN-1:0] w;
    out_ready = (($urandom % 100) < or_pct);
    if (m_recv) begin
      instruction    = 2'($urandom);
      approval_grant = !(drop_at >= 0 && beats_total >= drop_at);
      slave_valid    = (($urandom % 100) < sv_pct);
      w              = words[m_word % 16];
      rx_data        = slave_valid ? w[m_beat*LANES +: LANES] : LANES'($urandom);
    end else if (start_req) begin
      instruction    = 2'b11;
      approval_grant = 1'b1;
      slave_valid    = 1'($urandom);
      rx_data        = LANES'($urandom);
    end else begin
      instruction    = 2'($urandom_range(0, 2));
      approval_grant = 1'($urandom);
      slave_valid    = 1'($urandom);
      rx_data        = LANES'($urandom);
    end
  endtask

  task automatic model_update();
    bit room;
    m_done_pulse  = 0;
    m_abort_pulse = 0;
    if (reset) begin
      exp_q.delete();
      m_recv = 0; m_done_state = 0; start_req = 0;
      return;
    end
    room = m_recv && (exp_q.size() < FIFO_DEPTH);
    if (out_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      popped++;
    end
    if (m_done_state) begin
      m_done_state = 0;
    end else if (m_recv) begin
      if (!approval_grant) begin
        m_recv = 0; m_abort_pulse = 1; model_aborts++;
      end else if (slave_valid && room) begin
        m_idle = 0;
        beats_total++;
        m_beat++;
        if (m_beat == BEATS) begin
          exp_q.push_back(words[m_word]);
          m_beat = 0;
          m_word++;
          if (m_word == m_burst + 1) begin
            m_recv = 0; m_done_state = 1; m_done_pulse = 1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_recv = 0; m_abort_pulse = 1; model_aborts++;
        end
      end
    end else if (instruction == 2'b11 && approval_grant) begin
      m_recv = 1; start_req = 0;
      m_beat = 0; m_word = 0; m_idle = 0; beats_total = 0;
      m_burst = int'(burst_num);
    end
  endtask

  task automatic check_outputs();
    if (rx_abort === 1'b1) seen_aborts++;
    check("busy", 32'(busy), 32'(m_recv || m_done_state));
    check("master_ready", 32'(master_ready), 32'(m_recv && exp_q.size() < FIFO_DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
    check("rx_done", 32'(rx_done), 32'(m_done_pulse));
    check("rx_abort", 32'(rx_abort), 32'(m_abort_pulse));
  endtask

  task automatic step();
    choose_inputs();
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while ((start_req || m_recv || m_done_state) && n < bound) begin
      step();
      n++;
    end
    tests++;
    assert (!(start_req || m_recv || m_done_state)) else begin
      fails++;
      $error("FAIL %s cycle bound %0d expired observed=busy expected=idle", tag, bound);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    or_pct = 100;
    while (exp_q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_burst(input int n, input bit rnd);
    burst_num = BURST_LEN'(n);
    if (rnd) foreach (words[i]) words[i] = DATA_LEN'($urandom);
    start_req = 1;
  endtask

  initial begin
    reset = 1'b1; instruction = '0; approval_grant = 1'b0; burst_num = '0;
    slave_valid = 1'b0; rx_data = '0; out_ready = 1'b0;
    sv_pct = 100; or_pct = 100; drop_at = -1;
    popped = 0; model_aborts = 0; seen_aborts = 0;
    m_recv = 0; m_done_state = 0; start_req = 0;
    step(); step();
    check("reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    // Single-word burst of a known pattern.
    words[0] = 8'hA5;
    start_burst(0, 0);
    wait_idle("single_word", 40);
    drain("single_word");

    // Three-word burst of fixed words.
    words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
    popped = 0;
    start_burst(2, 0);
    wait_idle("three_words", 60);
    drain("three_words");
    check("three_words_popped", 32'(popped), 32'd3);

    // Consumer stalled: FIFO fills, master_ready drops, then resumes.
    popped = 0; or_pct = 0;
    start_burst(5, 1);
    repeat (40) step();
    check("stall_ready_low", 32'(master_ready), 32'd0);
    check("stall_fifo_full", 32'(exp_q.size()), 32'(FIFO_DEPTH));
    or_pct = 100;
    wait_idle("stall_resume", 80);
    drain("stall_resume");
    check("stall_popped", 32'(popped), 32'd6);

    // Grant dropped after three beats of the second word.
    popped = 0; drop_at = BEATS + 3; or_pct = 0;
    start_burst(3, 1);
    wait_idle("grant_drop", 60);
    drop_at = -1;
    drain("grant_drop");
    check("grant_drop_popped", 32'(popped), 32'd1);

    // No beats offered at all: idle timeout.
    sv_pct = 0;
    start_burst(1, 1);
    wait_idle("timeout", TIMEOUT + 20);
    check("timeout_busy", 32'(busy), 32'd0);
    sv_pct = 100;

    // Reset in the middle of a burst with two words queued.
    or_pct = 0;
    start_burst(5, 1);
    begin
      int n = 0;
      while (exp_q.size() < 2 && n < 60) begin step(); n++; end
    end
    check("pre_reset_queued", 32'(exp_q.size()), 32'd2);
    reset = 1'b1;
    step();
    check("mid_reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    or_pct = 100;
    repeat (2) step();

    // Randomized bursts with random backpressure, gaps and occasional grant loss.
    for (int b = 0; b < 15; b++) begin
      sv_pct  = $urandom_range(30, 100);
      or_pct  = $urandom_range(0, 100);
      drop_at = (($urandom % 4) == 0) ? $urandom_range(0, 20) : -1;
      start_burst($urandom_range(0, 6), 1);
      wait_idle("random_burst", 2000);
      drop_at = -1;
      drain("random_burst");
      repeat ($urandom_range(0, 3)) step();
    end

    check("abort_count", 32'(seen_aborts), 32'(model_aborts));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/master_rx_engine.md
MASTER_RX_ENGINE -- requirements
Module: master_rx_engine

Interface
REQ-001 SHALL have parameter DATA_LEN, default 8, meaning word width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 13, meaning burst_num width.
REQ-003 SHALL have parameter LANES, default 1, meaning serial data lanes; DATA_LEN SHALL be a multiple of LANES.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; power of 2, at least 2.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning maximum idle cycles between beats.
REQ-006 clk  input  1  clock; all logic on its rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 instruction  input  2  transaction request; 2'b11 = read.
REQ-009 approval_grant  input  1  bus grant from arbiter.
REQ-010 burst_num  input  BURST_LEN  words in burst minus one; sampled at start.
REQ-011 slave_valid  input  1  slave drives valid beat on rx_data.
REQ-012 rx_data  input  LANES  serial data lanes from slave.
REQ-013 master_ready  output  1  master accepts a beat this cycle.
REQ-014 out_valid / out_ready  output / input  1 / 1  word-stream handshake.
REQ-015 out_data  output  DATA_LEN  head FIFO word.
REQ-016 rx_done  output  1  one-cycle pulse, burst complete.
REQ-017 rx_abort  output  1  one-cycle pulse, burst aborted.
REQ-018 busy  output  1  high while state is not IDLE.

Function
REQ-019 States SHALL be IDLE, RECEIVE and DONE.
REQ-020 IDLE->RECEIVE SHALL occur when instruction==2'b11 and approval_grant==1; burst_num latched, beat, word and timeout counters cleared.
REQ-021 master_ready SHALL be high, combinationally, only in RECEIVE while the FIFO is not full.
REQ-022 A beat SHALL be accepted only when slave_valid && master_ready; its LANES bits are written to positions [beat*LANES +: LANES] of the assembly register, LSB-first.
REQ-023 The DATA_LEN/LANES-th beat SHALL push the completed word (including that beat's bits) into the FIFO in the same cycle and clear the beat counter.
REQ-024 Burst length SHALL be burst_num+1 words; burst_num=0 means one word; word counter BURST_LEN+1 bits wide, no wrap.
REQ-025 After the last word is pushed, state SHALL go to DONE; DONE asserts rx_done for exactly one cycle, then goes to IDLE.
REQ-026 approval_grant low in RECEIVE SHALL discard the partial word, pulse rx_abort one cycle and go to IDLE; words already in the FIFO are kept.
REQ-027 TIMEOUT consecutive RECEIVE cycles without an accepted beat SHALL abort exactly as in REQ-026; counter clears on every accepted beat.
REQ-028 FIFO SHALL pop on out_valid && out_ready; out_valid = FIFO not empty; out_data = head word.
REQ-029 Latency: word pushed at cycle N SHALL be visible with out_valid at N+1, with no fall-through.
REQ-030 Simultaneous push and pop SHALL keep the count unchanged; push while full cannot occur because master_ready is low.
REQ-031 instruction SHALL be ignored outside IDLE; DONE ignores grant.

Reset
REQ-032 Reset SHALL force IDLE, clear all counters, FIFO pointers and assembly register, and drive master_ready=0, out_valid=0, out_data=0, rx_done=0, rx_abort=0, busy=0.
REQ-033 Reset mid-burst SHALL take priority over every event and discard all FIFO contents.

Structure
REQ-034 A shared package SHALL hold the state encoding and the constant INSTR_READ=2'b11.
REQ-035 The FIFO SHALL be a separate sub-module rx_fifo, parameterised by width and depth, with full/empty/count outputs.

Verification
REQ-036 LANES=1, burst_num=0, bits of 8'hA5 LSB-first with slave_valid continuous -> one push at 8th beat, out_data=8'hA5 next cycle, rx_done pulse once.
REQ-037 LANES=2, burst_num=2, words 8'h12,8'h34,8'h56 -> 12 beats, three words popped in order, rx_done after third push.
REQ-038 out_ready=0, FIFO_DEPTH=4, burst_num=5 -> master_ready drops after 4 words; raising out_ready resumes; all 6 words delivered intact.
REQ-039 Grant dropped after 3 beats of word 2 -> rx_abort pulse, word 1 still popped, no partial word emitted.
REQ-040 slave_valid held low 255 cycles in RECEIVE -> rx_abort on the timeout cycle, state IDLE, busy=0.
REQ-041 Reset asserted mid-burst with 2 words queued -> next cycle out_valid=0, master_ready=0, busy=0.
